// File: rtl/box_if.sv
// Player-box bus between the box controller and the painter side.
// The controller takes the slave view; whoever drives the button and
// consumes the box position takes the master view.
interface box_if;
  logic       jump;
  logic [6:0] box_y;
  logic       draw;
  logic       frame_tick;
  logic       hit_floor;

  modport master (
    output jump,
    input  box_y,
    input  draw,
    input  frame_tick,
    input  hit_floor
  );

  modport slave (
    input  jump,
    output box_y,
    output draw,
    output frame_tick,
    output hit_floor
  );
endinterface

// File: rtl/box_controller.sv
// Player box vertical motion controller.
// A free-running frame counter paces the game. Once per frame the box
// velocity is updated (gravity or jump impulse), the box is moved and
// clamped to the screen, and the painter gets a fixed-length draw request.
//
// state      | meaning
// WAIT_FRAME | idle, box_y stable, waiting for a frame tick
// UPDATE     | choose new velocity, compute unclamped next row
// CLAMP      | fit the row into [Y_MIN, Y_MAX], publish box_y
// DRAW       | draw held high for HOLD_CYCLES cycles
module box_controller #(
  parameter int FRAME_CYCLES = 833333,
  parameter int GRAVITY      = 1,
  parameter int JUMP_VEL     = 4,
  parameter int MAX_FALL     = 4,
  parameter int Y_MIN        = 1,
  parameter int Y_MAX        = 118,
  parameter int Y_START      = 60,
  parameter int HOLD_CYCLES  = 16
) (
  input  logic clk,
  input  logic reset,
  box_if.slave bus
);

  localparam int FW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [FW-1:0]     FRAME_LAST = FW'(FRAME_CYCLES - 1);
  localparam logic [HW-1:0]     HOLD_LOAD  = HW'(HOLD_CYCLES - 1);
  localparam logic signed [6:0] GRAV7      = 7'(GRAVITY);
  localparam logic signed [6:0] MAXF7      = 7'(MAX_FALL);
  localparam logic signed [5:0] MAXF6      = 6'(MAX_FALL);
  localparam logic signed [5:0] JUMP_NEG   = -6'(JUMP_VEL);
  localparam logic signed [8:0] YMAX9      = 9'(Y_MAX);
  localparam logic signed [8:0] YMIN9      = 9'(Y_MIN);

  typedef enum logic [1:0] {
    WAIT_FRAME,
    UPDATE,
    CLAMP,
    DRAW
  } state_t;

  state_t             state;
  logic [FW-1:0]      frame_cnt;
  logic [HW-1:0]      hold_cnt;
  logic signed [5:0]  vel;
  logic signed [8:0]  next_y;
  logic [6:0]         box_y;
  logic               draw;
  logic               hit_floor;
  logic               jump_prev;
  logic               jump_pending;
  logic               tick_pending;
  logic               frame_tick;
  logic               jump_edge;

  logic signed [6:0]  vel_sum;
  logic signed [5:0]  vel_upd;
  logic signed [8:0]  y_sum;

  assign frame_tick = (frame_cnt == FRAME_LAST);
  assign jump_edge  = bus.jump & ~jump_prev;

  assign bus.box_y      = box_y;
  assign bus.draw       = draw;
  assign bus.frame_tick = frame_tick;
  assign bus.hit_floor  = hit_floor;

  // Frame pacing: free-running wrap counter, never stalled by the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (frame_tick) begin
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + FW'(1);
    end
  end

  // Velocity and row arithmetic, widened so nothing wraps before the clamp.
  always_comb begin
    vel_sum = $signed({vel[5], vel}) + GRAV7;
    vel_upd = vel_sum[5:0];
    if (jump_pending) begin
      vel_upd = JUMP_NEG;
    end else if (vel_sum > MAXF7) begin
      vel_upd = MAXF6;
    end
    y_sum = $signed({2'b00, box_y}) + $signed({{3{vel_upd[5]}}, vel_upd});
  end

  // Frame sequencer with jump capture and one-deep tick backlog.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= WAIT_FRAME;
      box_y        <= 7'(Y_START);
      vel          <= '0;
      next_y       <= '0;
      draw         <= 1'b0;
      hit_floor    <= 1'b0;
      hold_cnt     <= '0;
      jump_prev    <= 1'b0;
      jump_pending <= 1'b0;
      tick_pending <= 1'b0;
    end else begin
      hit_floor <= 1'b0;
      jump_prev <= bus.jump;
      if (jump_edge) begin
        jump_pending <= 1'b1;
      end
      if (frame_tick && state != WAIT_FRAME) begin
        tick_pending <= 1'b1;
      end
      case (state)
        WAIT_FRAME: begin
          if (frame_tick || tick_pending) begin
            tick_pending <= 1'b0;
            state        <= UPDATE;
          end
        end
        UPDATE: begin
          vel          <= vel_upd;
          next_y       <= y_sum;
          // Flag the floor clip so the pulse coincides with the CLAMP cycle.
          hit_floor    <= (y_sum > YMAX9);
          // An edge landing in this very cycle survives for the next frame.
          jump_pending <= jump_edge;
          state        <= CLAMP;
        end
        CLAMP: begin
          if (next_y > YMAX9) begin
            box_y <= 7'(Y_MAX);
            vel   <= '0;
          end else if (next_y < YMIN9) begin
            box_y <= 7'(Y_MIN);
            vel   <= '0;
          end else begin
            box_y <= next_y[6:0];
          end
          draw     <= 1'b1;
          hold_cnt <= HOLD_LOAD;
          state    <= DRAW;
        end
        DRAW: begin
          if (hold_cnt == '0) begin
            draw  <= 1'b0;
            state <= WAIT_FRAME;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        default: state <= WAIT_FRAME;
      endcase
    end
  end

endmodule
